// File: rtl/pulse_train_gen_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_gen_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_train_gen.sv
// Emits N single-cycle pulses separated by G idle cycles, then strobes done.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic             pulse,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] glen_q, glen_d;
  logic             pulse_q, busy_q, done_q;

  assign cmd_ready = (state_q == IDLE) && !abort;
  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    glen_d  = glen_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          glen_d = cmd_gap;
          if (cmd_count == '0) begin
            state_d = DONE;
            rem_d   = '0;
          end else begin
            state_d = PULSE;
            rem_d   = cmd_count - CNT_W'(1);
          end
        end
      end
      PULSE: begin
        // rem_q already excludes the pulse on the line this cycle
        if (abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (rem_q == '0) begin
          state_d = DONE;
        end else if (glen_q == '0) begin
          rem_d = rem_q - CNT_W'(1);
        end else begin
          state_d = GAP;
          gap_d   = glen_q;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (gap_q == GAP_W'(1)) begin
          state_d = PULSE;
          rem_d   = rem_q - CNT_W'(1);
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        rem_d   = '0;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      glen_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      glen_q  <= glen_d;
      pulse_q <= (state_d == PULSE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed and random trains against a timing-formula model.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_count;
  logic [3:0] cmd_gap;
  logic       abort;
  logic       pulse;
  logic       busy;
  logic [7:0] remaining;
  logic       done;

  pulse_train_gen #(.CNT_W(8), .GAP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .cmd_gap   (cmd_gap),
    .abort     (abort),
    .pulse     (pulse),
    .busy      (busy),
    .remaining (remaining),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit checking = 0;
  bit last_accept = 0;
  int cnt_obs = 0;

  // Model: a train accepted in cycle t0 is fully described by N, G and the offset from t0+1.
  bit act = 0;
  int t0 = 0;
  int mN = 0;
  int mG = 0;

  function automatic int olen();
    return (mN == 0) ? 0 : mN + (mN - 1) * mG;
  endfunction

  function automatic bit m_idle(input int c);
    return !act || (c - t0 - 1) > olen();
  endfunction

  function automatic bit m_in_train(input int c);
    return act && (c - t0 - 1) >= 0 && (c - t0 - 1) < olen();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit v, input int n, input int g, input bit ab, input bit r);
    bit acc;
    bit ab_hit;
    int o;
    bit ep, ed, eb;
    int er;
    cmd_valid = v;
    cmd_count = 8'(n);
    cmd_gap   = 4'(g);
    abort     = ab;
    rst       = r;
    #1;
    if (checking && !r) chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_idle(cyc) && !ab});
    acc    = !r && v && !ab && m_idle(cyc);
    ab_hit = !r && ab && m_in_train(cyc);
    @(posedge clk);
    #1;
    cyc++;
    last_accept = acc;
    if (r || ab_hit) act = 0;
    else if (acc) begin
      act = 1; t0 = cyc - 1; mN = n; mG = g; cnt_obs = 0;
    end
    if (pulse === 1'b1) cnt_obs++;
    if (r) checking = 1;
    if (checking) begin
      ep = 0; ed = 0; eb = 0; er = 0;
      if (act) begin
        o = cyc - t0 - 1;
        if (o < olen()) begin
          ep = (o % (mG + 1)) == 0;
          eb = 1;
          er = mN - 1 - o / (mG + 1);
        end else if (o == olen()) begin
          ed = 1;
          eb = 1;
        end
      end
      chk("pulse", {31'b0, pulse}, {31'b0, ep});
      chk("done", {31'b0, done}, {31'b0, ed});
      chk("busy", {31'b0, busy}, {31'b0, eb});
      chk("remaining", {24'b0, remaining}, 32'(er));
      if (ed) chk("pulse_total", 32'(cnt_obs), 32'(mN));
    end
  endtask

  task automatic send(input int n, input int g);
    int k;
    k = 0;
    last_accept = 0;
    while (!last_accept && k < 20) begin
      step(1, n, g, 0, 0);
      k++;
    end
    chk("accept_in_time", {31'b0, last_accept}, 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!m_idle(cyc) && k < 5000) begin
      step(0, 0, 0, 0, 0);
      k++;
    end
    chk("drain_in_time", {31'b0, m_idle(cyc)}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int abort_at;
    int k;
    int n;
    int g;
    cmd_valid = 0; cmd_count = 0; cmd_gap = 0; abort = 0; rst = 1;

    // Reset then idle with no command.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);

    // Basic spaced train, back-to-back train, zero-count command.
    send(3, 2);  drain();
    send(5, 0);  drain();
    send(0, 7);  drain();
    step(0, 0, 0, 0, 0);

    // A command offered together with abort in IDLE is refused.
    step(1, 3, 1, 1, 0);
    chk("abort_blocks_accept", {31'b0, last_accept}, 32'd0);
    step(0, 0, 0, 0, 0);

    // Abort in the second gap: two pulses, then a fresh single-pulse command.
    send(10, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("abort_pulse_total", 32'(cnt_obs), 32'd2);
    send(1, 0);
    chk("accept_after_abort", {31'b0, last_accept}, 32'd1);
    drain();

    // Reset during a long back-to-back train.
    send(255, 0);
    for (int i = 0; i < 99; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Maximum count and gap with cmd_valid held high throughout.
    send(255, 15);
    k = 0;
    while (!m_idle(cyc) && k < 5000) begin
      step(1, $urandom_range(0, 255), $urandom_range(0, 15), 0, 0);
      chk("no_second_accept", {31'b0, last_accept}, 32'd0);
      k++;
    end
    step(0, 0, 0, 0, 0);

    // Random trains with occasional aborts and idle spacing.
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 12);
      g = $urandom_range(0, 3);
      send(n, g);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, olen() + 2) : -1;
      k = 0;
      while (!m_idle(cyc) && k < 200) begin
        step(0, 0, 0, k == abort_at, 0);
        k++;
      end
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) step(0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
